// File: rtl/stage_fetch0_bp.sv
// Fetch-0 PC generation stage: redirect selection, icache request, and a
// direct-mapped BTB (zero-latency lookup) plus a speculation-epoch ID.
module stage_fetch0_bp #(
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned SPECID_W    = 2,
    parameter logic [29:0] RESET_PC    = 30'h0
) (
    input  logic                clk_core,
    input  logic                reset,
    output logic                fe0_valid,
    input  logic                fe1_stall,
    output logic [SPECID_W-1:0] fe0_specid,
    output logic                fe0_pred_taken,
    output logic                fe0_read_req,
    output logic [8:0]          fe0_read_asid,
    output logic [29:0]         fe0_read_addr,
    input  logic                de_setpc,
    input  logic                de_setspecid,
    input  logic [29:0]         de_newpc,
    input  logic                csr_fe_inhibit,
    input  logic                csr_setpc,
    input  logic [29:0]         csr_newpc,
    input  logic [31:0]         csr_satp,
    input  logic                csr_btb_flush,
    input  logic                ex_btb_upd,
    input  logic                ex_btb_taken,
    input  logic [29:0]         ex_btb_pc,
    input  logic [29:0]         ex_btb_target
);
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [29:0]            pc_q, pc_d;
    logic [SPECID_W-1:0]    specid_q, specid_d;
    logic [BTB_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
    logic [8:0]             asid_q   [BTB_ENTRIES];
    logic [8:0]             asid_d   [BTB_ENTRIES];
    logic [29:0]            target_q [BTB_ENTRIES];
    logic [29:0]            target_d [BTB_ENTRIES];

    logic             specid_inc;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_match;

    assign fe0_read_asid = csr_satp[30:22];
    assign fe0_read_req  = ~reset & ~fe1_stall & ~csr_fe_inhibit;
    assign fe0_valid     = fe0_read_req;

    always_comb begin
        fe0_read_addr = pc_q;
        if (csr_setpc)
            fe0_read_addr = csr_newpc;
        else if (de_setpc)
            fe0_read_addr = de_newpc;
    end

    assign lk_idx = fe0_read_addr[IDX_W-1:0];
    assign lk_tag = fe0_read_addr[29:IDX_W];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) &&
                    (asid_q[lk_idx] == fe0_read_asid);
    assign fe0_pred_taken = fe0_read_req & lk_hit;

    // An unissued address (stall/inhibit) is held, which also captures a redirect.
    always_comb begin
        pc_d = fe0_read_addr;
        if (fe0_read_req)
            pc_d = lk_hit ? target_q[lk_idx] : fe0_read_addr + 30'd1;
    end

    // The epoch bump applies to the redirect fetch in the same cycle.
    assign specid_inc = de_setpc & de_setspecid;
    assign specid_d   = specid_q + SPECID_W'(specid_inc);
    assign fe0_specid = reset ? SPECID_W'(specid_inc) : specid_d;

    assign up_idx   = ex_btb_pc[IDX_W-1:0];
    assign up_tag   = ex_btb_pc[29:IDX_W];
    assign up_match = (tag_q[up_idx] == up_tag) && (asid_q[up_idx] == fe0_read_asid);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        asid_d   = asid_q;
        target_d = target_q;
        if (csr_btb_flush) begin
            valid_d = '0;
        end else if (ex_btb_upd) begin
            if (ex_btb_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                asid_d[up_idx]   = fe0_read_asid;
                target_d[up_idx] = ex_btb_target;
            end else if (up_match) begin
                valid_d[up_idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            specid_q <= '0;
            valid_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            specid_q <= specid_d;
            valid_q  <= valid_d;
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk_core) begin
        tag_q    <= tag_d;
        asid_q   <= asid_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_stage_fetch0_bp.sv
// Directed bench for stage_fetch0_bp with hand-computed expectations.
module tb_stage_fetch0_bp;
    logic        clk_core = 1'b0;
    logic        reset;
    logic        fe0_valid;
    logic        fe1_stall;
    logic [1:0]  fe0_specid;
    logic        fe0_pred_taken;
    logic        fe0_read_req;
    logic [8:0]  fe0_read_asid;
    logic [29:0] fe0_read_addr;
    logic        de_setpc, de_setspecid;
    logic [29:0] de_newpc;
    logic        csr_fe_inhibit, csr_setpc;
    logic [29:0] csr_newpc;
    logic [31:0] csr_satp;
    logic        csr_btb_flush;
    logic        ex_btb_upd, ex_btb_taken;
    logic [29:0] ex_btb_pc, ex_btb_target;

    int errors = 0;
    int checks = 0;

    stage_fetch0_bp #(.BTB_ENTRIES(16), .SPECID_W(2), .RESET_PC(30'h100)) dut (
        .clk_core(clk_core), .reset(reset), .fe0_valid(fe0_valid), .fe1_stall(fe1_stall),
        .fe0_specid(fe0_specid), .fe0_pred_taken(fe0_pred_taken), .fe0_read_req(fe0_read_req),
        .fe0_read_asid(fe0_read_asid), .fe0_read_addr(fe0_read_addr), .de_setpc(de_setpc),
        .de_setspecid(de_setspecid), .de_newpc(de_newpc), .csr_fe_inhibit(csr_fe_inhibit),
        .csr_setpc(csr_setpc), .csr_newpc(csr_newpc), .csr_satp(csr_satp),
        .csr_btb_flush(csr_btb_flush), .ex_btb_upd(ex_btb_upd), .ex_btb_taken(ex_btb_taken),
        .ex_btb_pc(ex_btb_pc), .ex_btb_target(ex_btb_target)
    );

    always #5 clk_core = ~clk_core;

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic clear_ins();
        fe1_stall = 0; de_setpc = 0; de_setspecid = 0; de_newpc = '0;
        csr_fe_inhibit = 0; csr_setpc = 0; csr_newpc = '0; csr_btb_flush = 0;
        ex_btb_upd = 0; ex_btb_taken = 0; ex_btb_pc = '0; ex_btb_target = '0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if (fe0_read_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", fe0_read_req); end
        checks++; if (fe0_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", fe0_valid); end
        checks++; if (fe0_specid !== 2'd0) begin errors++; $display("FAIL rst_specid: got %0d want 0", fe0_specid); end
        checks++; if (fe0_read_addr !== 30'h100) begin errors++; $display("FAIL rst_addr: got %h want 100", fe0_read_addr); end
        de_setpc = 1; de_setspecid = 1; de_newpc = 30'h55; #1;
        checks++; if (fe0_specid !== 2'd1) begin errors++; $display("FAIL rst_specid_redir: got %0d want 1", fe0_specid); end
        checks++; if (fe0_read_addr !== 30'h55) begin errors++; $display("FAIL rst_addr_redir: got %h want 55", fe0_read_addr); end
        clear_ins();
        tick();
        reset = 0; #1;
        checks++; if (fe0_read_addr !== 30'h100 || fe0_read_req !== 1'b1 || fe0_pred_taken !== 1'b0)
            begin errors++; $display("FAIL first_fetch: got addr=%h req=%b pt=%b want 100/1/0", fe0_read_addr, fe0_read_req, fe0_pred_taken); end
        checks++; if (fe0_specid !== 2'd0) begin errors++; $display("FAIL first_specid: got %0d want 0", fe0_specid); end
        tick();
        checks++; if (fe0_read_addr !== 30'h101 || fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL seq_101: got %h pt=%b", fe0_read_addr, fe0_pred_taken); end
        tick();
        checks++; if (fe0_read_addr !== 30'h102 || fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL seq_102: got %h pt=%b", fe0_read_addr, fe0_pred_taken); end
    endtask

    task automatic test_train();
        tick();
        ex_btb_upd = 1; ex_btb_taken = 1; ex_btb_pc = 30'h102; ex_btb_target = 30'h200;
        tick();
        clear_ins(); de_setpc = 1; de_newpc = 30'h100; #1;
        checks++; if (fe0_read_addr !== 30'h100 || fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL train_100: got %h pt=%b", fe0_read_addr, fe0_pred_taken); end
        tick(); de_setpc = 0; #1;
        checks++; if (fe0_read_addr !== 30'h101 || fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL train_101: got %h pt=%b", fe0_read_addr, fe0_pred_taken); end
        tick();
        checks++; if (fe0_read_addr !== 30'h102 || fe0_pred_taken !== 1'b1) begin errors++; $display("FAIL train_102: got %h pt=%b want 102/1", fe0_read_addr, fe0_pred_taken); end
        tick();
        checks++; if (fe0_read_addr !== 30'h200 || fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL train_200: got %h pt=%b want 200/0", fe0_read_addr, fe0_pred_taken); end
        tick();
        checks++; if (fe0_read_addr !== 30'h201) begin errors++; $display("FAIL train_201: got %h want 201", fe0_read_addr); end
    endtask

    task automatic test_untaken();
        tick();
        ex_btb_upd = 1; ex_btb_taken = 0; ex_btb_pc = 30'h112;
        tick();
        clear_ins(); de_setpc = 1; de_newpc = 30'h102; #1;
        checks++; if (fe0_pred_taken !== 1'b1) begin errors++; $display("FAIL alias_keep: got pt=%b want 1", fe0_pred_taken); end
        tick(); de_setpc = 0; #1;
        checks++; if (fe0_read_addr !== 30'h200) begin errors++; $display("FAIL alias_tgt: got %h want 200", fe0_read_addr); end
        tick();
        ex_btb_upd = 1; ex_btb_taken = 0; ex_btb_pc = 30'h102;
        tick();
        clear_ins(); de_setpc = 1; de_newpc = 30'h102; #1;
        checks++; if (fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL untaken_clr: got pt=%b want 0", fe0_pred_taken); end
        tick(); de_setpc = 0; #1;
        checks++; if (fe0_read_addr !== 30'h103) begin errors++; $display("FAIL untaken_next: got %h want 103", fe0_read_addr); end
    endtask

    task automatic test_stall_redirect();
        tick();
        fe1_stall = 1; de_setpc = 1; de_setspecid = 1; de_newpc = 30'h300; #1;
        checks++; if (fe0_read_req !== 1'b0 || fe0_valid !== 1'b0) begin errors++; $display("FAIL stall_c1: got req=%b valid=%b want 0", fe0_read_req, fe0_valid); end
        checks++; if (fe0_specid !== 2'd1) begin errors++; $display("FAIL stall_specid: got %0d want 1", fe0_specid); end
        tick(); de_setpc = 0; de_setspecid = 0; #1;
        checks++; if (fe0_read_req !== 1'b0 || fe0_read_addr !== 30'h300) begin errors++; $display("FAIL stall_c2: got req=%b addr=%h", fe0_read_req, fe0_read_addr); end
        tick();
        checks++; if (fe0_read_req !== 1'b0 || fe0_read_addr !== 30'h300) begin errors++; $display("FAIL stall_c3: got req=%b addr=%h", fe0_read_req, fe0_read_addr); end
        tick(); fe1_stall = 0; #1;
        checks++; if (fe0_read_req !== 1'b1 || fe0_read_addr !== 30'h300 || fe0_specid !== 2'd1)
            begin errors++; $display("FAIL stall_issue: got req=%b addr=%h sid=%0d want 1/300/1", fe0_read_req, fe0_read_addr, fe0_specid); end
        tick();
        checks++; if (fe0_read_addr !== 30'h301) begin errors++; $display("FAIL stall_next: got %h want 301", fe0_read_addr); end
    endtask

    task automatic test_specid();
        logic [1:0] exp_sid;
        tick();
        reset = 1; de_setpc = 1; de_newpc = 30'h77; #1;
        checks++; if (fe0_read_req !== 1'b0 || fe0_read_addr !== 30'h77 || fe0_specid !== 2'd0)
            begin errors++; $display("FAIL midrst: got req=%b addr=%h sid=%0d want 0/77/0", fe0_read_req, fe0_read_addr, fe0_specid); end
        tick();
        reset = 0; de_setpc = 0; #1;
        checks++; if (fe0_read_addr !== 30'h100 || fe0_specid !== 2'd0) begin errors++; $display("FAIL midrst_after: got %h sid=%0d", fe0_read_addr, fe0_specid); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            de_setpc = 1; de_setspecid = 1; de_newpc = 30'h40 + 30'(k); #1;
            exp_sid = 2'(k);
            checks++; if (fe0_specid !== exp_sid) begin errors++; $display("FAIL specid_%0d: got %0d want %0d", k, fe0_specid, exp_sid); end
        end
        tick();
        de_setpc = 0; de_setspecid = 0; csr_setpc = 1; csr_newpc = 30'h500; #1;
        checks++; if (fe0_specid !== 2'd0 || fe0_read_addr !== 30'h500) begin errors++; $display("FAIL csr_redir: got sid=%0d addr=%h want 0/500", fe0_specid, fe0_read_addr); end
        tick();
        csr_newpc = 30'h600; de_setpc = 1; de_newpc = 30'h700; de_setspecid = 1; #1;
        checks++; if (fe0_read_addr !== 30'h600 || fe0_specid !== 2'd1) begin errors++; $display("FAIL csr_de_both: got addr=%h sid=%0d want 600/1", fe0_read_addr, fe0_specid); end
        tick();
        clear_ins(); #1;
        checks++; if (fe0_read_addr !== 30'h601 || fe0_specid !== 2'd1) begin errors++; $display("FAIL csr_de_after: got addr=%h sid=%0d want 601/1", fe0_read_addr, fe0_specid); end
    endtask

    task automatic test_flush_asid();
        tick();
        ex_btb_upd = 1; ex_btb_taken = 1; ex_btb_pc = 30'h105; ex_btb_target = 30'h250;
        tick();
        clear_ins(); de_setpc = 1; de_newpc = 30'h105; #1;
        checks++; if (fe0_pred_taken !== 1'b1) begin errors++; $display("FAIL pre_flush_hit: got pt=%b want 1", fe0_pred_taken); end
        tick();
        de_setpc = 0; csr_btb_flush = 1; ex_btb_upd = 1; ex_btb_taken = 1; ex_btb_pc = 30'h102; ex_btb_target = 30'h200; #1;
        checks++; if (fe0_read_addr !== 30'h250) begin errors++; $display("FAIL pre_flush_tgt: got %h want 250", fe0_read_addr); end
        tick();
        clear_ins(); de_setpc = 1; de_newpc = 30'h105; #1;
        checks++; if (fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL flush_old: got pt=%b want 0", fe0_pred_taken); end
        tick(); de_newpc = 30'h102; #1;
        checks++; if (fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL flush_wins: got pt=%b want 0", fe0_pred_taken); end
        tick(); de_setpc = 0; #1;
        checks++; if (fe0_read_addr !== 30'h103) begin errors++; $display("FAIL flush_next: got %h want 103", fe0_read_addr); end
        tick();
        ex_btb_upd = 1; ex_btb_taken = 1; ex_btb_pc = 30'h107; ex_btb_target = 30'h280;
        tick();
        clear_ins(); de_setpc = 1; de_newpc = 30'h107; #1;
        checks++; if (fe0_pred_taken !== 1'b1) begin errors++; $display("FAIL asid0_hit: got pt=%b want 1", fe0_pred_taken); end
        tick(); csr_satp = 32'h0140_0000; #1;
        checks++; if (fe0_read_asid !== 9'd5) begin errors++; $display("FAIL asid_out: got %0d want 5", fe0_read_asid); end
        checks++; if (fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL asid5_miss: got pt=%b want 0", fe0_pred_taken); end
        tick(); de_setpc = 0; #1;
        checks++; if (fe0_read_addr !== 30'h108) begin errors++; $display("FAIL asid5_next: got %h want 108", fe0_read_addr); end
        tick(); csr_satp = '0; de_setpc = 1; de_newpc = 30'h107; #1;
        checks++; if (fe0_pred_taken !== 1'b1) begin errors++; $display("FAIL asid0_again: got pt=%b want 1", fe0_pred_taken); end
    endtask

    task automatic test_back_to_back();
        tick();
        ex_btb_upd = 1; ex_btb_taken = 1; ex_btb_pc = 30'h110; ex_btb_target = 30'h400;
        de_setpc = 1; de_newpc = 30'h110; #1;
        checks++; if (fe0_pred_taken !== 1'b0) begin errors++; $display("FAIL same_cyc_old: got pt=%b want 0", fe0_pred_taken); end
        tick();
        ex_btb_upd = 0; #1;
        checks++; if (fe0_pred_taken !== 1'b1) begin errors++; $display("FAIL next_cyc_new: got pt=%b want 1", fe0_pred_taken); end
        tick(); de_setpc = 0; #1;
        checks++; if (fe0_read_addr !== 30'h400) begin errors++; $display("FAIL b2b_tgt: got %h want 400", fe0_read_addr); end
        tick(); de_setpc = 1; de_newpc = 30'h3FFF_FFFF; #1;
        checks++; if (fe0_read_addr !== 30'h3FFF_FFFF) begin errors++; $display("FAIL wrap_top: got %h", fe0_read_addr); end
        tick(); de_setpc = 0; #1;
        checks++; if (fe0_read_addr !== 30'h0) begin errors++; $display("FAIL wrap_zero: got %h want 0", fe0_read_addr); end
        tick(); csr_fe_inhibit = 1; #1;
        checks++; if (fe0_read_req !== 1'b0 || fe0_read_addr !== 30'h1) begin errors++; $display("FAIL inhibit: got req=%b addr=%h want 0/1", fe0_read_req, fe0_read_addr); end
        tick(); csr_fe_inhibit = 0; #1;
        checks++; if (fe0_read_req !== 1'b1 || fe0_read_addr !== 30'h1) begin errors++; $display("FAIL inhibit_hold: got req=%b addr=%h want 1/1", fe0_read_req, fe0_read_addr); end
    endtask

    initial begin
        reset = 1; csr_satp = '0;
        clear_ins();
        test_reset();
        test_train();
        test_untaken();
        test_stall_redirect();
        test_specid();
        test_flush_asid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stage_fetch0_bp.md
# stage_fetch0_bp

Parametrised next-generation fetch-0 (PC generation) stage with a direct-mapped branch target buffer (BTB) and a multi-bit speculation ID. Each cycle it picks the fetch address from CSR redirect, decode redirect, or its PC register, and issues it to the icache. It looks the address up in the BTB so that the following fetch goes to the predicted target instead of PC+4. It sits between the CSR/decode redirect sources and stage fetch1/icache. Execute trains it and the CSR unit flushes it.

## Interface
Parameters:
- BTB_ENTRIES, 16, number of BTB entries; must be a power of two, ≥2; IDX_W = log2(BTB_ENTRIES)
- SPECID_W, 2, width of speculation ID
- RESET_PC, 30'h0, word address [31:2] loaded on reset

Ports:
- clk_core  in  1  core clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- fe0_valid  out  1  equals fe0_read_req
- fe1_stall  in  1  fetch1 cannot accept
- fe0_specid  out  SPECID_W  speculation ID tagged on issued fetch
- fe0_pred_taken  out  1  issued fetch hit a valid BTB entry
- fe0_read_req  out  1  icache request
- fe0_read_asid  out  9  csr_satp[30:22]
- fe0_read_addr  out  30  [31:2] fetch word address
- de_setpc, de_setspecid  in  1 each  decode redirect / redirect opens new speculation epoch
- de_newpc  in  30  decode redirect target
- csr_fe_inhibit  in  1  suppress fetch
- csr_setpc  in  1  CSR redirect (trap/xret)
- csr_newpc  in  30  CSR redirect target
- csr_satp  in  32  satp CSR
- csr_btb_flush  in  1  invalidate all BTB entries
- ex_btb_upd  in  1  BTB training strobe
- ex_btb_taken  in  1  resolved branch/jump was taken
- ex_btb_pc, ex_btb_target  in  30 each  branch word address / resolved target

## Operation
- Address select (comb): csr_setpc → csr_newpc; else de_setpc → de_newpc; else pc register.
- fe0_read_req = ~reset & ~fe1_stall & ~csr_fe_inhibit.
- BTB entry holds: valid, tag = addr[31:IDX_W+2], asid[8:0], target[31:2]. Index = addr[IDX_W+1:2].
- Lookup (comb) on fe0_read_addr. A hit requires valid, tag match, and asid == fe0_read_asid. fe0_pred_taken = fe0_read_req & hit.
- PC register next value:
  - reset → RESET_PC.
  - fe0_read_req & hit → BTB target.
  - fe0_read_req & ~hit → fe0_read_addr + 1, wrapping mod 2^30.
  - otherwise (stall or inhibit) → fe0_read_addr. This holds the PC, or latches a redirect that was not issued so the redirect is never lost.
- Speculation ID:
  - SPECID_W-bit counter, reset 0.
  - Increments mod 2^SPECID_W when de_setpc & de_setspecid.
  - fe0_specid = counter + (de_setpc & de_setspecid), so the new ID applies to the same-cycle redirect fetch.
  - csr_setpc does not change the ID.
- Training (registered write):
  - ex_btb_upd & ex_btb_taken: write the entry at index(ex_btb_pc) with valid=1, tag, current asid and target. This overwrites any existing occupant.
  - ex_btb_upd & ~ex_btb_taken: clear valid at that index only if tag and asid match; otherwise no change.
- csr_btb_flush clears every valid bit. If flush and update occur in the same cycle, flush wins and the update is dropped.
- Reset clears all valid bits; targets and tags are don't-care.

## Timing
- Lookup latency 0: the hit/target is used in the same cycle it is issued. The PC register takes the predicted target at the next edge.
- A BTB write or flush in cycle N is visible to a lookup in cycle N+1. A lookup in cycle N sees the old contents.
- Output values while reset is high:
  - fe0_read_req = fe0_valid = fe0_pred_taken = 0.
  - fe0_specid = 0 unless decode asserts a specid redirect.
  - fe0_read_addr follows the select.
- After reset deasserts, the first issued address is RESET_PC (absent redirects).
- Reset asserted mid-operation takes effect at the next edge regardless of any other input.
- Redirect and stall in the same cycle: no request is issued and the redirect target is latched. It is issued on the first unstalled cycle.
- csr_setpc and de_setpc together: CSR target used. If de_setspecid is also set, specid still increments.

## Test plan
- Reset, RESET_PC=0x100, no stalls → read_addr 0x100, 0x101, 0x102 on consecutive cycles, pred_taken=0.
- Train taken pc=0x102 target=0x200, then refetch from 0x100 → 0x100, 0x101, 0x102 (pred_taken=1), 0x200, 0x201.
- Untaken update at 0x102 with matching tag, then refetch → 0x102 followed by 0x103. A not-taken update for an aliasing pc (same index, different tag) leaves the entry intact.
- fe1_stall high 3 cycles coincident with de_setpc=0x300 → read_req=0 for 3 cycles, then 0x300, 0x301. fe0_specid increments once when de_setspecid=1.
- SPECID_W=2: four specid redirects → fe0_specid sequence 1, 2, 3, 0 (wrap). csr_setpc → no change.
- Same-cycle flush + taken update → all subsequent lookups miss. Change satp ASID → a previously trained entry misses.
